// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the multiport register file
package regfile_pkg;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 32;
   localparam int REG_ZERO_ADDR = 0;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one bypassed, masked read lane; registered when REGFILE_SYNC_READ_EN is defined
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int ZERO_REG = 1,
   parameter int ADDR_W = clog2(DEPTH)
) (
`ifdef REGFILE_SYNC_READ_EN
   input  logic                   clock,
   input  logic                   reset,
`endif
   input  logic [DEPTH*WIDTH-1:0] regs,
   input  logic [ADDR_W-1:0]      addr,
   input  logic                   wr_ok,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       data
);
   logic [WIDTH-1:0] sel;
   logic [WIDTH-1:0] value;
   logic             masked;
   always_comb begin
      sel = '0;
      for (int i = 0; i < DEPTH; i++)
         if (32'(addr) == i) sel = regs[i*WIDTH +: WIDTH];
   end
   assign masked = 32'(addr) >= DEPTH || (ZERO_REG != 0 && 32'(addr) == REG_ZERO_ADDR);
   assign value  = (wr_ok && wr_addr == addr) ? wr_data : masked ? '0 : sel;
`ifdef REGFILE_SYNC_READ_EN
   always_ff @(posedge clock or posedge reset)
      if (reset) data <= '0;
      else data <= value;
`else
   assign data = value;
`endif
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: DEPTHxWIDTH register file, one write port, NUM_READ bypassed read ports; REGFILE_SYNC_READ_EN registers the read lanes
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int NUM_READ = 2,
   parameter int ZERO_REG = 1,
   localparam int ADDR_W = clog2(DEPTH)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       ctrl_writeEnable,
   input  logic [ADDR_W-1:0]          ctrl_writeReg,
   input  logic [WIDTH-1:0]           data_writeReg,
   input  logic [NUM_READ*ADDR_W-1:0] ctrl_readReg,
   output logic [NUM_READ*WIDTH-1:0]  data_readReg
);
   logic [DEPTH*WIDTH-1:0] regs;
   logic                   wr_ok;
   // reset also blocks bypass so every lane reads 0 while it is held
   assign wr_ok = ctrl_writeEnable && !reset && 32'(ctrl_writeReg) < DEPTH &&
                  !(ZERO_REG != 0 && 32'(ctrl_writeReg) == REG_ZERO_ADDR);
   always_ff @(posedge clock or posedge reset)
      if (reset) regs <= '0;
      else if (wr_ok) regs[32'(ctrl_writeReg)*WIDTH +: WIDTH] <= data_writeReg;
   for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
      regfile_read_port #(
         .WIDTH(WIDTH),
         .DEPTH(DEPTH),
         .ZERO_REG(ZERO_REG),
         .ADDR_W(ADDR_W)
      ) u_rd (
`ifdef REGFILE_SYNC_READ_EN
         .clock(clock),
         .reset(reset),
`endif
         .regs(regs),
         .addr(ctrl_readReg[k*ADDR_W +: ADDR_W]),
         .wr_ok(wr_ok),
         .wr_addr(ctrl_writeReg),
         .wr_data(data_writeReg),
         .data(data_readReg[k*WIDTH +: WIDTH])
      );
   end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed vectors on 32x32/ZERO_REG=1 and 24-deep/ZERO_REG=0 files plus a random 16x8x4 sweep
module tb_regfile_multiport;
   logic        clock = 1'b0;
   logic        reset;
   logic        we_ab;
   logic [4:0]  wa_ab;
   logic [31:0] wd_ab;
   logic [9:0]  ra_ab;
   logic [63:0] data_a, data_b;
   logic        we_c;
   logic [2:0]  wa_c;
   logic [15:0] wd_c;
   logic [11:0] ra_c;
   logic [63:0] data_c;
   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   regfile_multiport #(.WIDTH(32), .DEPTH(32), .NUM_READ(2), .ZERO_REG(1)) dut_a (
      .clock(clock), .reset(reset), .ctrl_writeEnable(we_ab), .ctrl_writeReg(wa_ab),
      .data_writeReg(wd_ab), .ctrl_readReg(ra_ab), .data_readReg(data_a));
   regfile_multiport #(.WIDTH(32), .DEPTH(24), .NUM_READ(2), .ZERO_REG(0)) dut_b (
      .clock(clock), .reset(reset), .ctrl_writeEnable(we_ab), .ctrl_writeReg(wa_ab),
      .data_writeReg(wd_ab), .ctrl_readReg(ra_ab), .data_readReg(data_b));
   regfile_multiport #(.WIDTH(16), .DEPTH(8), .NUM_READ(4), .ZERO_REG(1)) dut_c (
      .clock(clock), .reset(reset), .ctrl_writeEnable(we_c), .ctrl_writeReg(wa_c),
      .data_writeReg(wd_c), .ctrl_readReg(ra_c), .data_readReg(data_c));

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  r0, r1;
      logic [31:0] a0, a1, b0, b1;
   } vec_t;

   function automatic vec_t mk(input int we, input int wa, input logic [31:0] wd, input int r0,
                               input int r1, input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] b0, input logic [31:0] b1);
      vec_t v;
      v.we = (we != 0);
      v.wa = 5'(wa);
      v.wd = wd;
      v.r0 = 5'(r0);
      v.r1 = 5'(r1);
      v.a0 = a0;
      v.a1 = a1;
      v.b0 = b0;
      v.b1 = b1;
      return v;
   endfunction

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reach the point where the lanes reflect the current inputs.
   task automatic settle;
`ifdef REGFILE_SYNC_READ_EN
      @(posedge clock);
      #1;
`else
      #1;
`endif
   endtask

   task automatic finish_cycle;
`ifndef REGFILE_SYNC_READ_EN
      @(posedge clock);
      #1;
`endif
   endtask

   task automatic apply(input string tag, input vec_t v);
      we_ab = v.we;
      wa_ab = v.wa;
      wd_ab = v.wd;
      ra_ab = {v.r1, v.r0};
      settle();
      chk32({tag, " A0"}, data_a[31:0], v.a0);
      chk32({tag, " A1"}, data_a[63:32], v.a1);
      chk32({tag, " B0"}, data_b[31:0], v.b0);
      chk32({tag, " B1"}, data_b[63:32], v.b1);
      finish_cycle();
   endtask

   vec_t tv[15];
   logic [15:0] model[8];
   logic [63:0] exp_c;
   logic [2:0]  ra;

   initial begin
      tv[0]  = mk(1, 7, 32'h12345678, 0, 0, 0, 0, 0, 0);
      tv[1]  = mk(0, 0, 0, 7, 7, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);
      tv[2]  = mk(1, 3, 32'hA5A5A5A5, 7, 3, 32'h12345678, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5);
      tv[3]  = mk(0, 0, 0, 3, 3, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
      tv[4]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      tv[5]  = mk(0, 0, 0, 0, 7, 0, 32'h12345678, 32'hFFFFFFFF, 32'h12345678);
      tv[6]  = mk(1, 31, 32'hCAFEF00D, 31, 30, 32'hCAFEF00D, 0, 0, 0);
      tv[7]  = mk(1, 31, 32'h11111111, 31, 31, 32'h11111111, 32'h11111111, 0, 0);
      tv[8]  = mk(0, 31, 32'h22222222, 31, 3, 32'h11111111, 32'hA5A5A5A5, 0, 32'hA5A5A5A5);
      tv[9]  = mk(1, 7, 0, 7, 1, 0, 0, 0, 0);
      tv[10] = mk(0, 0, 0, 7, 31, 0, 32'h11111111, 0, 0);
      tv[11] = mk(1, 30, 32'h55, 30, 23, 32'h55, 0, 0, 0);
      tv[12] = mk(1, 23, 32'h77, 23, 30, 32'h77, 32'h55, 32'h77, 0);
      tv[13] = mk(0, 0, 0, 23, 30, 32'h77, 32'h55, 32'h77, 0);
      tv[14] = mk(0, 0, 0, 23, 0, 32'h77, 0, 32'h77, 32'hFFFFFFFF);

      reset = 1'b1;
      we_ab = 1'b0; wa_ab = '0; wd_ab = '0; ra_ab = {5'd5, 5'd0};
      we_c = 1'b0; wa_c = '0; wd_c = '0; ra_c = '0;
      repeat (2) @(posedge clock);
      #1;
      chk64("reset A", data_a, 64'h0);
      chk64("reset B", data_b, 64'h0);
      chk64("reset C", data_c, 64'h0);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) apply($sformatf("vec%0d", i), tv[i]);

      apply("pre_rst_wr", mk(1, 5, 32'hDEADBEEF, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF));
      apply("pre_rst_rd", mk(0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF));
      #3;
      we_ab = 1'b1; wa_ab = 5'd5; wd_ab = 32'h12345678; ra_ab = {5'd5, 5'd5};
      reset = 1'b1;
      #1;
      chk64("mid_rst A", data_a, 64'h0);
      chk64("mid_rst B", data_b, 64'h0);
      @(posedge clock);
      #1;
      chk64("rst_wr A", data_a, 64'h0);
      chk64("rst_wr B", data_b, 64'h0);
      reset = 1'b0;
      apply("post_rst5", mk(0, 0, 0, 5, 23, 0, 0, 0, 0));
      apply("post_rst0", mk(0, 0, 0, 0, 3, 0, 0, 0, 0));

      for (int j = 0; j < 8; j++) model[j] = '0;
      for (int n = 0; n < 2000; n++) begin
         we_c = 1'($urandom_range(0, 1));
         wa_c = 3'($urandom);
         wd_c = 16'($urandom);
         ra_c = 12'($urandom);
         for (int k = 0; k < 4; k++) begin
            ra = ra_c[k*3 +: 3];
            exp_c[k*16 +: 16] = (we_c && wa_c != 3'd0 && wa_c == ra) ? wd_c :
                                (ra == 3'd0) ? 16'h0 : model[ra];
         end
         settle();
         chk64($sformatf("sweep%0d", n), data_c, exp_c);
         if (we_c && wa_c != 3'd0) model[wa_c] = wd_c;
         finish_cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
